traffic_phase_controller: RTL and testbench
===========================================

# traffic_phase_controller

Sequencing controller for the main/side intersection signal path. Holds the four-phase state register and the phase-duration timer, and advances main-green → main-yellow → side-green → side-yellow on a slow timebase strobe. Its 2-bit state output is the select input of the combinational light decoder, whose start-long/start-short indications correspond to the duration this block loads on phase entry. With the sensor option built in, main green is held until a side-road vehicle request is pending.

## Interface
- `LONG_TICKS`, default 30: green phase duration in `tick_en` strobes; valid range 1..2^`CNT_W`.
- `SHORT_TICKS`, default 5: yellow phase duration in `tick_en` strobes; valid range 1..2^`CNT_W`.
- `CNT_W`, default 8: width of the phase timer.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `tick_en`  in  1  timebase strobe, one `clk` wide; timer counts only on strobes.
- `side_req`  in  1  side-road vehicle sensor, level, synchronous to `clk`.
- `state_out`  out  2  current phase: 00 main green, 01 main yellow, 11 side green, 10 side yellow.
- `remaining`  out  `CNT_W`  strobes left in the current phase minus one (0 = final strobe).
- `phase_start`  out  1  one-cycle pulse in the first cycle of every new phase.
- `side_pend`  out  1  latched side request awaiting service.

## Operation
- Gray-coded cycle, one bit changes per transition: S0 00 → S1 01 → S2 11 → S3 10 → S0.
- On entry to S0/S2, `remaining` loads `LONG_TICKS-1`; on entry to S1/S3 it loads `SHORT_TICKS-1`.
- In a cycle with `tick_en`=1: if `remaining`>0, decrement; if `remaining`=0, the phase expires and the next state is taken (subject to the S0 hold rule below).
- In a cycle with `tick_en`=0, `remaining` and `state_out` hold.
- `phase_start` is registered: high for exactly one cycle, in the cycle `state_out` first shows the new value.
- `side_pend` set on any cycle with `side_req`=1 while in S0 or S1; cleared on entry to S2; `side_req` ignored in S2/S3.
- Arithmetic: `remaining` never wraps; the decrement only happens when the value is nonzero.

## Timing
- Reset (async assert): `state_out`=00, `remaining`=`LONG_TICKS-1`, `phase_start`=0, `side_pend`=0. Reset mid-phase aborts the phase immediately; no yellow is forced.
- After deassert, S0 runs a full `LONG_TICKS` strobes; `phase_start` does not pulse for the reset entry.
- Each phase lasts exactly its duration in strobes: the expiring strobe is the Nth, and the new state appears on the `clk` edge ending that strobe cycle (one-cycle latency).
- `side_req` in the same cycle as the S0 expiry strobe counts as pending for that expiry decision.
- Every state transition reloads the timer; expiry and reload occur on the same edge.

## Configuration
- `SIDE_SENSOR_EN` defined: in S0 with `remaining`=0 and `tick_en`=1 and `side_pend`=0 (and `side_req`=0), stay in S0 with `remaining` held at 0; advance to S1 on the first subsequent `tick_en` cycle with a pending request. The minimum main green therefore remains `LONG_TICKS`.
- `SIDE_SENSOR_EN` undefined: fixed-time cycle. `side_req` is ignored, `side_pend` is tied to 0, and S0 always advances at expiry.

## Test plan
- `LONG_TICKS`=4, `SHORT_TICKS`=2, `tick_en`=1 every cycle, sensor compiled out → `state_out` sequence is 00×4, 01×2, 11×4, 10×2, repeating every 12 cycles; `phase_start` pulses at cycles 4, 6, 10, 12.
- Same configuration with `tick_en` every 3rd cycle → each phase lasts 3× its duration in cycles; `remaining` is stable between strobes.
- `SIDE_SENSOR_EN` defined, `side_req`=0 → `state_out` stays 00 indefinitely with `remaining`=0. Pulse `side_req` for 1 cycle → `side_pend`=1, and 01 appears on the edge after the next strobe.
- `SIDE_SENSOR_EN` defined, `side_req` pulsed during S1 → `side_pend` is 1 until S2 entry, then 0. The next S0 holds at expiry.
- Assert `rst_n`=0 while in S2 with `remaining`=2 → outputs immediately become 00/`LONG_TICKS-1`/0/0 without a clock. After release, a full S0 runs with no `phase_start` pulse.
- `LONG_TICKS`=1, `SHORT_TICKS`=1 → the state advances on every strobe; `remaining` stays at 0 throughout.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - four-phase main/side intersection sequencer with phase timer
//
// Purpose: walks the Gray-coded phase cycle main green (00) -> main yellow (01)
// -> side green (11) -> side yellow (10), timing each phase in tick_en strobes.
// Green phases last LONG_TICKS strobes, yellow phases SHORT_TICKS strobes.
//
// Optional feature: define SIDE_SENSOR_EN to hold main green at expiry until a
// side-road request is pending. Undefined: fixed-time cycle, side_pend tied 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   tick_en     in   one-cycle timebase strobe; the timer only moves on strobes
//   side_req    in   side-road vehicle sensor level (used only with SIDE_SENSOR_EN)
//   state_out   out  current phase code, drives the light decoder select
//   remaining   out  strobes left in the phase minus one (0 = final strobe)
//   phase_start out  one-cycle pulse in the first cycle of each new phase
//   side_pend   out  latched side request awaiting service
module traffic_phase_controller #(
  parameter int LONG_TICKS  = 30,
  parameter int SHORT_TICKS = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             side_req,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_start,
  output logic             side_pend
);

  typedef enum logic [1:0] {
    S_MAIN_GREEN  = 2'b00,
    S_MAIN_YELLOW = 2'b01,
    S_SIDE_GREEN  = 2'b11,
    S_SIDE_YELLOW = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_TICKS - 1);

  phase_t           r_state;
  phase_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_load;
  logic             r_phase_start;
  logic             w_expire;
  logic             w_hold;
  logic             w_enter_side_green;

  always_comb begin
    w_next = S_MAIN_GREEN;
    case (r_state)
      S_MAIN_GREEN:  w_next = S_MAIN_YELLOW;
      S_MAIN_YELLOW: w_next = S_SIDE_GREEN;
      S_SIDE_GREEN:  w_next = S_SIDE_YELLOW;
      S_SIDE_YELLOW: w_next = S_MAIN_GREEN;
      default:       w_next = S_MAIN_GREEN;
    endcase
  end

  // Duration loaded on entry depends on the phase being entered, not the one leaving.
  assign w_load = (w_next == S_MAIN_GREEN || w_next == S_SIDE_GREEN) ? LONG_LOAD : SHORT_LOAD;

  assign w_expire           = tick_en && (r_remaining == '0);
  assign w_enter_side_green = w_expire && (r_state == S_MAIN_YELLOW);

`ifdef SIDE_SENSOR_EN
  logic r_side_pend;

  // A request arriving in the expiry cycle itself counts for that decision.
  assign w_hold = (r_state == S_MAIN_GREEN) && !r_side_pend && !side_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_side_pend <= 1'b0;
    end else if (w_enter_side_green) begin
      r_side_pend <= 1'b0;
    end else if (side_req && (r_state == S_MAIN_GREEN || r_state == S_MAIN_YELLOW)) begin
      r_side_pend <= 1'b1;
    end
  end

  assign side_pend = r_side_pend;
`else
  logic w_unused_side_req;

  assign w_unused_side_req = side_req ^ w_enter_side_green;
  assign w_hold            = 1'b0;
  assign side_pend         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_MAIN_GREEN;
      r_remaining   <= LONG_LOAD;
      r_phase_start <= 1'b0;
    end else begin
      r_phase_start <= 1'b0;
      if (tick_en) begin
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - 1'b1;
        end else if (!w_hold) begin
          r_state       <= w_next;
          r_remaining   <= w_load;
          r_phase_start <= 1'b1;
        end
        // Holding main green leaves remaining parked at 0 until a request shows up.
      end
    end
  end

  assign state_out   = r_state;
  assign remaining   = r_remaining;
  assign phase_start = r_phase_start;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - scoreboard bench for traffic_phase_controller
module tb_traffic_phase_controller;

  localparam int LA = 4;
  localparam int SA = 2;
  localparam int WA = 8;
  localparam int LB = 1;
  localparam int SB = 1;
  localparam int WB = 1;

`ifdef SIDE_SENSOR_EN
  localparam bit SENSOR = 1'b1;
`else
  localparam bit SENSOR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick_en = 1'b0;
  logic          side_req = 1'b0;
  logic [1:0]    a_state;
  logic [WA-1:0] a_rem;
  logic          a_ps;
  logic          a_pend;
  logic [1:0]    b_state;
  logic [WB-1:0] b_rem;
  logic          b_ps;
  logic          b_pend;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  traffic_phase_controller #(.LONG_TICKS(LA), .SHORT_TICKS(SA), .CNT_W(WA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .side_req(side_req),
    .state_out(a_state), .remaining(a_rem), .phase_start(a_ps), .side_pend(a_pend)
  );

  traffic_phase_controller #(.LONG_TICKS(LB), .SHORT_TICKS(SB), .CNT_W(WB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .side_req(side_req),
    .state_out(b_state), .remaining(b_rem), .phase_start(b_ps), .side_pend(b_pend)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..3 in cycle order, durations in strobes.
  int m_p[2];
  int m_rem[2];
  int m_ps[2];
  int m_pend[2];
  int m_long[2]  = '{LA, LB};
  int m_short[2] = '{SA, SB};

  logic [11:0] qa[$];
  logic [4:0]  qb[$];

  function automatic logic [1:0] phase_code(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 0;
      m_rem[i] = m_long[i] - 1;
      m_ps[i] = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input bit tk, input bit rq);
    for (int i = 0; i < 2; i++) begin
      int oldp;
      bit entered_sg;
      oldp = m_p[i];
      entered_sg = 1'b0;
      m_ps[i] = 0;
      if (tk) begin
        if (m_rem[i] > 0) begin
          m_rem[i] = m_rem[i] - 1;
        end else if (!(SENSOR && oldp == 0 && m_pend[i] == 0 && !rq)) begin
          m_p[i] = (oldp + 1) % 4;
          m_rem[i] = (((m_p[i] % 2) == 0) ? m_long[i] : m_short[i]) - 1;
          m_ps[i] = 1;
          entered_sg = (m_p[i] == 2);
        end
      end
      if (!SENSOR) m_pend[i] = 0;
      else if (entered_sg) m_pend[i] = 0;
      else if (rq && oldp < 2) m_pend[i] = 1;
    end
  endtask

  function automatic logic [11:0] pack_a();
    logic [WA-1:0] r;
    r = WA'(m_rem[0]);
    return {phase_code(m_p[0]), r, m_ps[0] != 0, m_pend[0] != 0};
  endfunction

  function automatic logic [4:0] pack_b();
    logic [WB-1:0] r;
    r = WB'(m_rem[1]);
    return {phase_code(m_p[1]), r, m_ps[1] != 0, m_pend[1] != 0};
  endfunction

  task automatic cycle(input bit tk, input bit rq);
    @(negedge clk);
    tick_en = tk;
    side_req = rq;
    model_step(tk, rq);
    qa.push_back(pack_a());
    qb.push_back(pack_b());
    mon_en = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle; pop the expectation for this edge.
  always @(posedge clk) begin
    if (mon_en) begin
      logic [11:0] ea;
      logic [11:0] ga;
      logic [4:0]  eb;
      logic [4:0]  gb;
      #1;
      ga = {a_state, a_rem, a_ps, a_pend};
      gb = {b_state, b_rem, b_ps, b_pend};
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL dut_a_queue_empty at %0t: got %h, no expectation queued", $time, ga);
      end else begin
        ea = qa.pop_front();
        if (ga !== ea) begin
          fails++;
          $display("FAIL dut_a_outputs at %0t: got state=%b rem=%0d ps=%b pend=%b, need state=%b rem=%0d ps=%b pend=%b",
                   $time, ga[11:10], ga[9:2], ga[1], ga[0], ea[11:10], ea[9:2], ea[1], ea[0]);
        end
      end
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL dut_b_queue_empty at %0t: got %h, no expectation queued", $time, gb);
      end else begin
        eb = qb.pop_front();
        if (gb !== eb) begin
          fails++;
          $display("FAIL dut_b_outputs at %0t: got state=%b rem=%0d ps=%b pend=%b, need state=%b rem=%0d ps=%b pend=%b",
                   $time, gb[4:3], gb[2], gb[1], gb[0], eb[4:3], eb[2], eb[1], eb[0]);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    tests++;
    if (a_state !== 2'b00 || a_rem !== WA'(LA - 1) || a_ps !== 1'b0 || a_pend !== 1'b0) begin
      fails++;
      $display("FAIL %s_a: got state=%b rem=%0d ps=%b pend=%b, need 00/%0d/0/0",
               tag, a_state, a_rem, a_ps, a_pend, LA - 1);
    end
    tests++;
    if (b_state !== 2'b00 || b_rem !== WB'(LB - 1) || b_ps !== 1'b0 || b_pend !== 1'b0) begin
      fails++;
      $display("FAIL %s_b: got state=%b rem=%0d ps=%b pend=%b, need 00/%0d/0/0",
               tag, b_state, b_rem, b_ps, b_pend, LB - 1);
    end
  endtask

  initial begin
    int k;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_initial");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Strobe every cycle: 12-cycle fixed pattern on dut A, every strobe advances dut B.
    for (int i = 0; i < 36; i++) cycle(1'b1, SENSOR && (i % 7 == 2));

    // Strobe every third cycle; remaining must hold between strobes.
    for (int i = 0; i < 45; i++) cycle(i % 3 == 0, $urandom_range(0, 9) == 0);

    // Random strobes and requests.
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0);

    // No requests for a long stretch (main green holds with the sensor), then one pulse.
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(i % 2 == 0, 1'b0);

    // Seek side green with remaining=2 on dut A, then reset asynchronously.
    k = 0;
    while (!(m_p[0] == 2 && m_rem[0] == 2) && k < 200) begin
      cycle(1'b1, 1'b1);
      k++;
    end
    tests++;
    if (!(m_p[0] == 2 && m_rem[0] == 2)) begin
      fails++;
      $display("FAIL seek_side_green: got phase=%0d rem=%0d after %0d cycles, need phase=2 rem=2", m_p[0], m_rem[0], k);
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    tests++;
    if (a_state !== 2'b11 || a_rem !== WA'(2)) begin
      fails++;
      $display("FAIL pre_reset_state: got state=%b rem=%0d, need 11/2", a_state, a_rem);
    end
    rst_n = 1'b0;
    #1 check_reset_values("reset_mid_phase");
    model_reset();
    @(negedge clk);
    tick_en = 1'b1;
    side_req = 1'b1;
    @(negedge clk);
    #1 check_reset_values("reset_held");
    rst_n = 1'b1;
    tick_en = 1'b0;

    // Full main green after release with no start pulse for the reset entry.
    for (int i = 0; i < 24; i++) cycle(1'b1, $urandom_range(0, 3) == 0);

    @(posedge clk);
    #3;
    mon_en = 1'b0;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d/%0d expectations left, need 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
